// File: rtl/ledseq_pkg.sv
// ----------------------------------------------------------------------------
// Package : ledseq_pkg
// Shared types and constants for the LED pattern sequencer.
// Rev     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ledseq_pkg;

  localparam int NLEDS = 8;

  localparam logic [7:0] LFSR_SEED = 8'h01;
  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    MODE_SCAN    = 2'd0,
    MODE_CHASE_L = 2'd1,
    MODE_CHASE_R = 2'd2,
    MODE_BLINK   = 2'd3
  } mode_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int unsigned period_of(input int unsigned f_clk,
                                            input int unsigned f_evt);
    return f_clk / f_evt;
  endfunction

  function automatic logic [NLEDS-1:0] onehot(input logic [2:0] idx);
    return NLEDS'(1) << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_divider.sv
// ----------------------------------------------------------------------------
// Module : tick_divider
// Free-running counter emitting a one-cycle strobe every PERIOD clocks.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tick_divider #(
  parameter int unsigned PERIOD = 4
) (
  input  logic clk,
  input  logic clear,
  output logic tick
);

  localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clear || cnt == LAST) cnt <= '0;
    else                      cnt <= cnt + W'(1);
  end

  assign tick = (cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/led_pattern_sequencer.sv
// ----------------------------------------------------------------------------
// Module : led_pattern_sequencer
// Step/fade/PWM strobes and per-LED turn-on triggers; define LEDSEQ_LFSR_EN
// to turn mode 3 into LFSR random sparkle instead of blink-all.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module led_pattern_sequencer
  import ledseq_pkg::*;
#(
  parameter int unsigned FREQ_CLK  = 100_000_000,
  parameter int unsigned FREQ_STEP = 10,
  parameter int unsigned FREQ_FADE = 1000,
  parameter int unsigned FREQ_PWM  = 32'(64'(25) * 64'(FREQ_CLK) / 64'd128),
  parameter int unsigned CNT_W     = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [1:0]       speed_sel,
  input  logic [1:0]       mode_in,
  input  logic             mode_req,
  output logic             mode_busy,
  output logic             mode_ack,
  output logic [NLEDS-1:0] trig,
  output logic [2:0]       pos,
  output logic             fade_tick,
  output logic             pwm_tick
);

  localparam logic [CNT_W-1:0] BASE_PERIOD = CNT_W'(period_of(FREQ_CLK, FREQ_STEP));

  tick_divider #(.PERIOD(period_of(FREQ_CLK, FREQ_FADE))) u_fade_div (
    .clk   (clk),
    .clear (rst),
    .tick  (fade_tick)
  );

  tick_divider #(.PERIOD(period_of(FREQ_CLK, FREQ_PWM))) u_pwm_div (
    .clk   (clk),
    .clear (rst),
    .tick  (pwm_tick)
  );

  state_t state, state_nxt;
  logic   running;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (run)  state_nxt = ST_RUN;
      ST_RUN:  if (!run) state_nxt = ST_IDLE;
      default:           state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    running = (state == ST_RUN);
  end

  // Compare with >= so a faster speed_sel fires on the very next cycle
  logic [CNT_W-1:0] step_cnt;
  logic [CNT_W-1:0] step_period;
  logic             step_tick;

  assign step_period = BASE_PERIOD >> speed_sel;
  assign step_tick   = running && (step_cnt >= step_period - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst || !running || !run || step_tick) step_cnt <= '0;
    else                                      step_cnt <= step_cnt + CNT_W'(1);
  end

`ifdef LEDSEQ_LFSR_EN
  logic [7:0] lfsr;
  logic [7:0] lfsr_nxt;

  assign lfsr_nxt = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? LFSR_TAPS : 8'h00);

  always_ff @(posedge clk) begin
    if (rst)            lfsr <= LFSR_SEED;
    else if (step_tick) lfsr <= lfsr_nxt;
  end
`endif

  mode_t            mode, pend_mode, eff_mode;
  logic             dir_up, eff_up, up_nxt;
  logic [2:0]       eff_pos, pos_nxt;
  logic [NLEDS-1:0] trig_nxt;
  logic             apply;

  assign apply = step_tick && mode_busy;

  // A pending mode is applied first, so this step emits its first pattern
  always_comb begin
    eff_mode = mode;
    eff_pos  = pos;
    eff_up   = dir_up;
    if (apply) begin
      eff_mode = pend_mode;
      eff_pos  = (pend_mode == MODE_CHASE_R) ? 3'd7 : 3'd0;
      eff_up   = 1'b1;
    end
  end

  always_comb begin
    trig_nxt = '0;
    pos_nxt  = eff_pos;
    up_nxt   = eff_up;
    case (eff_mode)
      MODE_SCAN: begin
        trig_nxt = onehot(eff_pos);
        if (eff_up) begin
          if (eff_pos == 3'd7) begin
            up_nxt  = 1'b0;
            pos_nxt = 3'd6;
          end else begin
            pos_nxt = eff_pos + 3'd1;
          end
        end else begin
          if (eff_pos == 3'd0) begin
            up_nxt  = 1'b1;
            pos_nxt = 3'd1;
          end else begin
            pos_nxt = eff_pos - 3'd1;
          end
        end
      end
      MODE_CHASE_L: begin
        trig_nxt = onehot(eff_pos);
        pos_nxt  = eff_pos + 3'd1;
      end
      MODE_CHASE_R: begin
        trig_nxt = onehot(eff_pos);
        pos_nxt  = eff_pos - 3'd1;
      end
      default: begin
`ifdef LEDSEQ_LFSR_EN
        trig_nxt = onehot(lfsr_nxt[2:0]);
        pos_nxt  = lfsr_nxt[2:0];
`else
        trig_nxt = eff_pos[0] ? '0 : '1;
        pos_nxt  = {eff_pos[2:1], ~eff_pos[0]};
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig      <= '0;
      pos       <= 3'd0;
      dir_up    <= 1'b1;
      mode      <= MODE_SCAN;
      pend_mode <= MODE_SCAN;
      mode_busy <= 1'b0;
      mode_ack  <= 1'b0;
    end else begin
      trig     <= '0;
      mode_ack <= 1'b0;
      if (step_tick) begin
        trig   <= trig_nxt;
        pos    <= pos_nxt;
        dir_up <= up_nxt;
        mode   <= eff_mode;
      end
      if (apply) begin
        mode_ack  <= 1'b1;
        mode_busy <= 1'b0;
      end else if (mode_req && !mode_busy) begin
        pend_mode <= mode_t'(mode_in);
        mode_busy <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_sequencer.sv
// ----------------------------------------------------------------------------
// Module : tb_led_pattern_sequencer
// Directed bench with a cycle-level reference model of the pattern rules.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_led_pattern_sequencer;

  localparam int BASE = 1000 / 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [1:0] speed_sel = 2'd0;
  logic [1:0] mode_in = 2'd0;
  logic       mode_req = 1'b0;
  logic       mode_busy, mode_ack, fade_tick, pwm_tick;
  logic [7:0] trig;
  logic [2:0] pos;

  led_pattern_sequencer #(
    .FREQ_CLK (1000),
    .FREQ_STEP(100),
    .FREQ_FADE(250),
    .FREQ_PWM (500)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .speed_sel(speed_sel),
    .mode_in  (mode_in),
    .mode_req (mode_req),
    .mode_busy(mode_busy),
    .mode_ack (mode_ack),
    .trig     (trig),
    .pos      (pos),
    .fade_tick(fade_tick),
    .pwm_tick (pwm_tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int   scan_tab [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1};
  int   m_cnt, m_k, m_pos, m_mode, m_pend, m_strobe, m_per;
  bit   m_run, m_busy, m_tick, m_was_busy, m_valid = 1'b0;
  logic [7:0] e_trig;
  bit   e_ack;
`ifdef LEDSEQ_LFSR_EN
  logic [7:0] m_lfsr;
`endif

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_k = 0; m_pos = 0; m_mode = 0; m_pend = 0; m_strobe = 0;
      m_run = 1'b0; m_busy = 1'b0; e_trig = 8'h00; e_ack = 1'b0; m_valid = 1'b1;
`ifdef LEDSEQ_LFSR_EN
      m_lfsr = 8'h01;
`endif
    end else begin
      m_per      = BASE >> speed_sel;
      m_tick     = m_run && (m_cnt >= m_per - 1);
      m_was_busy = m_busy;
      e_trig     = 8'h00;
      e_ack      = 1'b0;
      m_strobe++;
      if (m_tick) begin
        if (m_was_busy) begin
          m_mode = m_pend;
          m_k    = 0;
          m_pos  = (m_pend == 2) ? 7 : 0;
          m_busy = 1'b0;
          e_ack  = 1'b1;
        end
`ifdef LEDSEQ_LFSR_EN
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
`endif
        case (m_mode)
          0: begin e_trig = 8'd1 << scan_tab[m_k]; m_k = (m_k + 1) % 14; end
          1: begin e_trig = 8'd1 << m_pos; m_pos = (m_pos + 1) % 8; end
          2: begin e_trig = 8'd1 << m_pos; m_pos = (m_pos + 7) % 8; end
          default: begin
`ifdef LEDSEQ_LFSR_EN
            e_trig = 8'd1 << m_lfsr[2:0];
            m_pos  = int'(m_lfsr[2:0]);
`else
            e_trig = (m_pos % 2 == 0) ? 8'hFF : 8'h00;
            m_pos  = m_pos ^ 1;
`endif
          end
        endcase
      end
      if (!m_was_busy && mode_req) begin
        m_busy = 1'b1;
        m_pend = int'(mode_in);
      end
      m_cnt = (!m_run || !run || m_tick) ? 0 : m_cnt + 1;
      m_run = run;
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("trig",      32'(trig),      32'(e_trig));
      chk("pos",       32'(pos),       32'((m_mode == 0) ? scan_tab[m_k] : m_pos));
      chk("mode_ack",  32'(mode_ack),  32'(e_ack));
      chk("mode_busy", 32'(mode_busy), 32'(m_busy));
      chk("fade_tick", 32'(fade_tick), 32'(m_strobe % 4 == 3));
      chk("pwm_tick",  32'(pwm_tick),  32'(m_strobe % 2 == 1));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_trig(input int bound, output int n);
    n = 0;
    do begin
      step_cycle();
      n++;
    end while (trig == 8'h00 && n < bound);
    if (trig == 8'h00) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_trig: no trig within %0d cycles at t=%0t", bound, $time);
    end
  endtask

  task automatic pulse_req(input logic [1:0] m);
    mode_in  = m;
    mode_req = 1'b1;
    step_cycle();
    mode_req = 1'b0;
  endtask

  logic [7:0] scan_exp [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};
  logic [7:0] chase_exp [5] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20};

  initial begin
    int n;
    step_cycle();
    step_cycle();
    rst = 1'b0;
    chk("rst_trig", 32'(trig), 32'h0);
    chk("rst_pos",  32'(pos),  32'h0);
    chk("rst_busy", 32'(mode_busy), 32'h0);
    chk("rst_ack",  32'(mode_ack), 32'h0);
    repeat (3) step_cycle();
    chk("fade_3rd", 32'(fade_tick), 32'h1);
    chk("pwm_3rd",  32'(pwm_tick),  32'h1);
    step_cycle();
    chk("fade_4th", 32'(fade_tick), 32'h0);

    // scan from reset, through the bounce at 7
    run = 1'b1;
    wait_trig(30, n);
    chk("first_latency", 32'(n), 32'd11);
    chk("scan_trig0", 32'(trig), 32'(scan_exp[0]));
    for (int i = 1; i < 9; i++) begin
      wait_trig(15, n);
      chk("scan_gap", 32'(n), 32'd10);
      chk("scan_trig", 32'(trig), 32'(scan_exp[i]));
    end
    chk("pause_pos", 32'(pos), 32'd5);

    // pause and resume
    run = 1'b0;
    repeat (25) step_cycle();
    chk("paused_pos", 32'(pos), 32'd5);
    run = 1'b1;
    wait_trig(30, n);
    chk("resume_latency", 32'(n), 32'd11);
    chk("resume_trig", 32'(trig), 32'h20);
    wait_trig(15, n);
    chk("pos3_trig", 32'(trig), 32'h10);

    // switch to chase right at pos 3, second request ignored
    pulse_req(2'd2);
    chk("busy_set", 32'(mode_busy), 32'h1);
    pulse_req(2'd1);
    wait_trig(15, n);
    chk("cr_latency", 32'(n), 32'd8);
    chk("cr_trig0", 32'(trig), 32'h80);
    chk("cr_ack", 32'(mode_ack), 32'h1);
    chk("cr_busy", 32'(mode_busy), 32'h0);
    wait_trig(15, n);
    chk("cr_trig1", 32'(trig), 32'h40);
    chk("cr_ack1", 32'(mode_ack), 32'h0);
    wait_trig(15, n);
    chk("cr_trig2", 32'(trig), 32'h20);

    // speed change mid-interval fires next cycle
    repeat (5) step_cycle();
    speed_sel = 2'd2;
    step_cycle();
    chk("speed_step", 32'(trig), 32'h10);
    wait_trig(5, n);
    chk("speed_gap", 32'(n), 32'd2);
    chk("speed_trig", 32'(trig), 32'h08);
    speed_sel = 2'd0;
    wait_trig(15, n);
    chk("slow_gap", 32'(n), 32'd10);

    // mode 3
    pulse_req(2'd3);
    wait_trig(15, n);
    chk("m3_ack", 32'(mode_ack), 32'h1);
`ifndef LEDSEQ_LFSR_EN
    chk("blink_trig0", 32'(trig), 32'hFF);
    wait_trig(30, n);
    chk("blink_gap", 32'(n), 32'd20);
    chk("blink_trig2", 32'(trig), 32'hFF);
`else
    wait_trig(15, n);
`endif

    // chase left, then reset with a pending request at pos 6
    pulse_req(2'd1);
    wait_trig(15, n);
    chk("cl_trig0", 32'(trig), 32'h01);
    chk("cl_ack", 32'(mode_ack), 32'h1);
    for (int i = 0; i < 5; i++) begin
      wait_trig(15, n);
      chk("cl_trig", 32'(trig), 32'(chase_exp[i]));
    end
    chk("cl_pos6", 32'(pos), 32'd6);
    pulse_req(2'd2);
    chk("pend_busy", 32'(mode_busy), 32'h1);
    step_cycle();
    rst = 1'b1;
    step_cycle();
    rst = 1'b0;
    chk("mid_rst_pos",  32'(pos), 32'h0);
    chk("mid_rst_busy", 32'(mode_busy), 32'h0);
    chk("mid_rst_trig", 32'(trig), 32'h0);
    wait_trig(30, n);
    chk("post_rst_latency", 32'(n), 32'd11);
    chk("post_rst_trig", 32'(trig), 32'h01);
    chk("post_rst_ack", 32'(mode_ack), 32'h0);
    wait_trig(15, n);
    chk("post_rst_scan", 32'(trig), 32'h02);
    repeat (20) step_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
